// File: rtl/biu_arb2.sv
// Two-requester arbiter in front of a single biu_ahb3lite instance.
// Requester 0 is instruction fetch, requester 1 is data access. Ownership is held until
// every beat of every accepted transfer has been acknowledged.

package biu_arb2_pkg;
  typedef logic [2:0] biu_size_t;
  typedef logic [2:0] biu_type_t;
  typedef logic [2:0] biu_prot_t;

  localparam biu_type_t SINGLE = 3'b000;
  localparam biu_type_t INCR   = 3'b001;
  localparam biu_type_t WRAP4  = 3'b010;
  localparam biu_type_t INCR4  = 3'b011;
  localparam biu_type_t WRAP8  = 3'b100;
  localparam biu_type_t INCR8  = 3'b101;
  localparam biu_type_t WRAP16 = 3'b110;
  localparam biu_type_t INCR16 = 3'b111;
endpackage

module biu_arb2
  import biu_arb2_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned ADDR_SIZE   = DATA_SIZE,
  parameter int unsigned MAX_PENDING = 32
) (
  input  logic                 HRESETn,
  input  logic                 HCLK,

  // Requester 0 (instruction fetch)
  input  logic                 m0_stb_i,
  output logic                 m0_stb_ack_o,
  output logic                 m0_d_ack_o,
  input  logic [ADDR_SIZE-1:0] m0_adri_i,
  output logic [ADDR_SIZE-1:0] m0_adro_o,
  input  biu_size_t            m0_size_i,
  input  biu_type_t            m0_type_i,
  input  biu_prot_t            m0_prot_i,
  input  logic                 m0_lock_i,
  input  logic                 m0_we_i,
  input  logic [DATA_SIZE-1:0] m0_d_i,
  output logic [DATA_SIZE-1:0] m0_q_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,

  // Requester 1 (data access)
  input  logic                 m1_stb_i,
  output logic                 m1_stb_ack_o,
  output logic                 m1_d_ack_o,
  input  logic [ADDR_SIZE-1:0] m1_adri_i,
  output logic [ADDR_SIZE-1:0] m1_adro_o,
  input  biu_size_t            m1_size_i,
  input  biu_type_t            m1_type_i,
  input  biu_prot_t            m1_prot_i,
  input  logic                 m1_lock_i,
  input  logic                 m1_we_i,
  input  logic [DATA_SIZE-1:0] m1_d_i,
  output logic [DATA_SIZE-1:0] m1_q_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,

  // BIU side
  output logic                 biu_stb_o,
  input  logic                 biu_stb_ack_i,
  input  logic                 biu_d_ack_i,
  output logic [ADDR_SIZE-1:0] biu_adri_o,
  input  logic [ADDR_SIZE-1:0] biu_adro_i,
  output biu_size_t            biu_size_o,
  output biu_type_t            biu_type_o,
  output biu_prot_t            biu_prot_o,
  output logic                 biu_lock_o,
  output logic                 biu_we_o,
  output logic [DATA_SIZE-1:0] biu_d_o,
  input  logic [DATA_SIZE-1:0] biu_q_i,
  input  logic                 biu_ack_i,
  input  logic                 biu_err_i,

  // Status
  output logic [1:0]           owner_o
);

  localparam int unsigned CntW = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        own0, own1;
  logic        owner_stb, owner_lock;
  logic [4:0]  beat_cnt;
  logic [31:0] need;
  logic        admit;
  logic        accept;

  // Beats one accepted strobe of the given burst type will return.
  function automatic logic [4:0] beats(input biu_type_t t);
    case (t)
      SINGLE, INCR:   beats = 5'd1;
      WRAP4,  INCR4:  beats = 5'd4;
      WRAP8,  INCR8:  beats = 5'd8;
      default:        beats = 5'd16;
    endcase
  endfunction

  assign own0 = (state_q == StOwn0);
  assign own1 = (state_q == StOwn1);

  // Forward the owner's request to the BIU; requester 0 drives the bus while idle.
  always_comb begin
    biu_adri_o = own1 ? m1_adri_i : m0_adri_i;
    biu_size_o = own1 ? m1_size_i : m0_size_i;
    biu_type_o = own1 ? m1_type_i : m0_type_i;
    biu_prot_o = own1 ? m1_prot_i : m0_prot_i;
    biu_we_o   = own1 ? m1_we_i   : m0_we_i;
    biu_d_o    = own1 ? m1_d_i    : m0_d_i;
    owner_stb  = (own0 & m0_stb_i)  | (own1 & m1_stb_i);
    owner_lock = (own0 & m0_lock_i) | (own1 & m1_lock_i);
    beat_cnt   = beats(biu_type_o);
    // Hold back a strobe whose beats would overflow the pending counter.
    need       = 32'(cnt_q) + 32'(beat_cnt);
    admit      = (need <= MAX_PENDING);
    biu_stb_o  = owner_stb & admit;
    biu_lock_o = owner_lock;
    accept     = biu_stb_o & biu_stb_ack_i;
    owner_o    = {own1, own0};
  end

  // Route handshakes to the owner only; read data and address go to both.
  always_comb begin
    m0_stb_ack_o = own0 & biu_stb_ack_i;
    m0_d_ack_o   = own0 & biu_d_ack_i;
    m0_ack_o     = own0 & biu_ack_i;
    m0_err_o     = own0 & biu_err_i;
    m1_stb_ack_o = own1 & biu_stb_ack_i;
    m1_d_ack_o   = own1 & biu_d_ack_i;
    m1_ack_o     = own1 & biu_ack_i;
    m1_err_o     = own1 & biu_err_i;
    m0_q_o       = biu_q_i;
    m1_q_o       = biu_q_i;
    m0_adro_o    = biu_adro_i;
    m1_adro_o    = biu_adro_i;
  end

  // Pending beats: add on accepted strobe, subtract on each ack, clear on error.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_d + CntW'(beat_cnt);
    end
    if (biu_ack_i) begin
      cnt_d = cnt_d - CntW'(1);
    end
    if (biu_err_i) begin
      cnt_d = '0;
    end
  end

  // Ownership: round-robin grant from idle, release once drained, unstrobed and unlocked.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (m0_stb_i && (!m1_stb_i || last_q)) begin
          state_d = StOwn0;
          last_d  = 1'b0;
        end else if (m1_stb_i) begin
          state_d = StOwn1;
          last_d  = 1'b1;
        end
      end
      StOwn0: begin
        if (cnt_d == '0 && !m0_stb_i && !m0_lock_i) begin
          if (m1_stb_i) begin
            state_d = StOwn1;
            last_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StOwn1: begin
        if (cnt_d == '0 && !m1_stb_i && !m1_lock_i) begin
          if (m0_stb_i) begin
            state_d = StOwn0;
            last_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_biu_arb2.sv
// Directed bench for biu_arb2: per-cycle vector table plus a hand-written async reset case.

module tb_biu_arb2;
  import biu_arb2_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  localparam logic [AW-1:0] A0 = 32'h0000_0100;
  localparam logic [AW-1:0] A1 = 32'h0000_0200;
  localparam logic [DW-1:0] D0 = 32'h0D0D_0D0D;
  localparam logic [DW-1:0] D1 = 32'h1D1D_1D1D;
  localparam biu_size_t     S0 = 3'd2;
  localparam biu_size_t     S1 = 3'd1;
  localparam biu_prot_t     P0 = 3'd3;
  localparam biu_prot_t     P1 = 3'd5;

  logic HRESETn, HCLK;

  logic m0_stb_i, m0_stb_ack_o, m0_d_ack_o, m0_lock_i, m0_we_i, m0_ack_o, m0_err_o;
  logic m1_stb_i, m1_stb_ack_o, m1_d_ack_o, m1_lock_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [AW-1:0] m0_adri_i, m0_adro_o, m1_adri_i, m1_adro_o;
  logic [DW-1:0] m0_d_i, m0_q_o, m1_d_i, m1_q_o;
  biu_size_t m0_size_i, m1_size_i, biu_size_o;
  biu_type_t m0_type_i, m1_type_i, biu_type_o;
  biu_prot_t m0_prot_i, m1_prot_i, biu_prot_o;
  logic biu_stb_o, biu_stb_ack_i, biu_d_ack_i, biu_lock_o, biu_we_o, biu_ack_i, biu_err_i;
  logic [AW-1:0] biu_adri_o, biu_adro_i;
  logic [DW-1:0] biu_d_o, biu_q_i;
  logic [1:0] owner_o;

  biu_arb2 #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MAX_PENDING(32)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .m0_stb_i(m0_stb_i), .m0_stb_ack_o(m0_stb_ack_o), .m0_d_ack_o(m0_d_ack_o),
    .m0_adri_i(m0_adri_i), .m0_adro_o(m0_adro_o), .m0_size_i(m0_size_i),
    .m0_type_i(m0_type_i), .m0_prot_i(m0_prot_i), .m0_lock_i(m0_lock_i), .m0_we_i(m0_we_i),
    .m0_d_i(m0_d_i), .m0_q_o(m0_q_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_stb_ack_o(m1_stb_ack_o), .m1_d_ack_o(m1_d_ack_o),
    .m1_adri_i(m1_adri_i), .m1_adro_o(m1_adro_o), .m1_size_i(m1_size_i),
    .m1_type_i(m1_type_i), .m1_prot_i(m1_prot_i), .m1_lock_i(m1_lock_i), .m1_we_i(m1_we_i),
    .m1_d_i(m1_d_i), .m1_q_o(m1_q_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
    .biu_adri_o(biu_adri_o), .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o),
    .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o),
    .biu_we_o(biu_we_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i),
    .biu_err_i(biu_err_i), .owner_o(owner_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // sl = {m0_stb, m1_stb, m0_lock, m1_lock}; hs = {stb_ack, d_ack, ack, err}
  // exp = {biu_stb, biu_lock, owner[1:0], sa0, sa1, da0, da1, ack0, ack1, err0, err1}
  typedef struct packed {
    logic [3:0]  sl;
    biu_type_t   t0;
    biu_type_t   t1;
    logic [3:0]  hs;
    logic [11:0] exp;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [3:0] sl, input biu_type_t t0, input biu_type_t t1,
                     input logic [3:0] hs, input logic [11:0] exp);
    vec_t v;
    v.sl = sl; v.t0 = t0; v.t1 = t1; v.hs = hs; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    {m0_stb_i, m1_stb_i, m0_lock_i, m1_lock_i} = v.sl;
    m0_type_i = v.t0;
    m1_type_i = v.t1;
    {biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i} = v.hs;
    biu_q_i    = 32'hA500_0000 + 32'(idx);
    biu_adro_i = 32'(idx) << 2;
  endtask

  function automatic logic [11:0] hs_out();
    return {biu_stb_o, biu_lock_o, owner_o, m0_stb_ack_o, m1_stb_ack_o, m0_d_ack_o,
            m1_d_ack_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
  endfunction

  initial begin
    logic sel1;
    HRESETn = 1'b0;
    m0_adri_i = A0; m1_adri_i = A1; m0_d_i = D0; m1_d_i = D1;
    m0_size_i = S0; m1_size_i = S1; m0_prot_i = P0; m1_prot_i = P1;
    m0_we_i = 1'b0; m1_we_i = 1'b1;
    m0_stb_i = 1'b1; m1_stb_i = 1'b1; m0_lock_i = 1'b1; m1_lock_i = 1'b1;
    m0_type_i = SINGLE; m1_type_i = SINGLE;
    biu_stb_ack_i = 1'b1; biu_d_ack_i = 1'b1; biu_ack_i = 1'b1; biu_err_i = 1'b1;
    biu_q_i = '0; biu_adro_i = '0;

    // Contention from reset, m0 INCR4 then direct handover to m1, then round-robin to m0
    add(4'b1100, INCR4,  SINGLE, 4'b0000, 12'b0000_0000_0000);
    add(4'b1100, INCR4,  SINGLE, 4'b1000, 12'b1001_1000_0000);
    for (int i = 0; i < 4; i++) add(4'b0100, INCR4, SINGLE, 4'b0010, 12'b0001_0000_1000);
    add(4'b0100, INCR4,  SINGLE, 4'b1000, 12'b1010_0100_0000);
    add(4'b0000, INCR4,  SINGLE, 4'b0010, 12'b0010_0000_0100);
    add(4'b1100, SINGLE, SINGLE, 4'b0000, 12'b0000_0000_0000);
    add(4'b1100, SINGLE, SINGLE, 4'b1000, 12'b1001_1000_0000);
    add(4'b0100, SINGLE, SINGLE, 4'b0010, 12'b0001_0000_1000);
    add(4'b0100, SINGLE, SINGLE, 4'b1000, 12'b1010_0100_0000);
    add(4'b0000, SINGLE, SINGLE, 4'b0010, 12'b0010_0000_0100);
    // m0 SINGLE read alone
    add(4'b1000, SINGLE, SINGLE, 4'b0000, 12'b0000_0000_0000);
    add(4'b1000, SINGLE, SINGLE, 4'b1000, 12'b1001_1000_0000);
    add(4'b0000, SINGLE, SINGLE, 4'b0010, 12'b0001_0000_1000);
    add(4'b0000, SINGLE, SINGLE, 4'b0000, 12'b0000_0000_0000);
    // m1 WRAP8 write, pipelined SINGLE accepted with the first ack: 9 acks in total
    add(4'b0100, SINGLE, WRAP8,  4'b0000, 12'b0000_0000_0000);
    add(4'b0100, SINGLE, WRAP8,  4'b1000, 12'b1010_0100_0000);
    add(4'b0100, SINGLE, SINGLE, 4'b1110, 12'b1010_0101_0100);
    for (int i = 0; i < 8; i++) add(4'b0000, SINGLE, SINGLE, 4'b0010, 12'b0010_0000_0100);
    add(4'b0000, SINGLE, SINGLE, 4'b0000, 12'b0000_0000_0000);
    // Error on beat 2 of m0 INCR4 while m1 waits
    add(4'b1100, INCR4,  SINGLE, 4'b0000, 12'b0000_0000_0000);
    add(4'b1100, INCR4,  SINGLE, 4'b1000, 12'b1001_1000_0000);
    add(4'b0100, INCR4,  SINGLE, 4'b0010, 12'b0001_0000_1000);
    add(4'b0100, INCR4,  SINGLE, 4'b0001, 12'b0001_0000_0010);
    add(4'b0100, INCR4,  SINGLE, 4'b1000, 12'b1010_0100_0000);
    add(4'b0000, INCR4,  SINGLE, 4'b0010, 12'b0010_0000_0100);
    add(4'b0000, SINGLE, SINGLE, 4'b0000, 12'b0000_0000_0000);
    // m0 lock holds ownership while m1 strobes for 5 cycles
    add(4'b1010, SINGLE, SINGLE, 4'b0000, 12'b0000_0000_0000);
    add(4'b1010, SINGLE, SINGLE, 4'b1000, 12'b1101_1000_0000);
    add(4'b0010, SINGLE, SINGLE, 4'b0010, 12'b0101_0000_1000);
    for (int i = 0; i < 5; i++) add(4'b0110, SINGLE, SINGLE, 4'b0000, 12'b0101_0000_0000);
    add(4'b0100, SINGLE, SINGLE, 4'b0000, 12'b0001_0000_0000);
    add(4'b0100, SINGLE, SINGLE, 4'b1000, 12'b1010_0100_0000);
    add(4'b0000, SINGLE, SINGLE, 4'b0010, 12'b0010_0000_0100);
    add(4'b0000, SINGLE, SINGLE, 4'b0000, 12'b0000_0000_0000);
    // Admission limit: 16+16 fills 32, a further SINGLE waits for one ack
    add(4'b1000, INCR16, SINGLE, 4'b0000, 12'b0000_0000_0000);
    add(4'b1000, INCR16, SINGLE, 4'b1000, 12'b1001_1000_0000);
    add(4'b1000, INCR16, SINGLE, 4'b1000, 12'b1001_1000_0000);
    add(4'b1000, SINGLE, SINGLE, 4'b0000, 12'b0001_0000_0000);
    add(4'b1000, SINGLE, SINGLE, 4'b0010, 12'b0001_0000_1000);
    add(4'b1000, SINGLE, SINGLE, 4'b1000, 12'b1001_1000_0000);
    for (int i = 0; i < 32; i++) add(4'b0000, SINGLE, SINGLE, 4'b0010, 12'b0001_0000_1000);
    add(4'b0000, SINGLE, SINGLE, 4'b0000, 12'b0000_0000_0000);

    // Reset state with every input active
    repeat (2) @(negedge HCLK);
    #2;
    check("reset_out", 128'(hs_out()), 128'(12'b0));
    check("reset_cnt", 128'(dut.cnt_q), 128'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], i);
      #2;
      sel1 = vq[i].exp[9];
      check($sformatf("vec%0d_hs", i), 128'(hs_out()), 128'(vq[i].exp));
      check($sformatf("vec%0d_fwd", i),
            128'({biu_adri_o, biu_d_o, biu_type_o, biu_size_o, biu_prot_o, biu_we_o}),
            128'({sel1 ? A1 : A0, sel1 ? D1 : D0, sel1 ? vq[i].t1 : vq[i].t0,
                  sel1 ? S1 : S0, sel1 ? P1 : P0, sel1}));
      check($sformatf("vec%0d_route", i), {m0_q_o, m1_q_o, m0_adro_o, m1_adro_o},
            {32'hA500_0000 + 32'(i), 32'hA500_0000 + 32'(i), 32'(i) << 2, 32'(i) << 2});
      @(negedge HCLK);
    end

    // Async reset in the middle of an m1 INCR16 with 10 beats outstanding
    {m0_stb_i, m1_stb_i, m0_lock_i, m1_lock_i} = 4'b0100;
    m1_type_i = INCR16;
    {biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i} = 4'b0000;
    @(negedge HCLK);
    biu_stb_ack_i = 1'b1;
    @(negedge HCLK);
    m1_stb_i = 1'b0;
    biu_stb_ack_i = 1'b0;
    biu_ack_i = 1'b1;
    repeat (6) @(negedge HCLK);
    biu_ack_i = 1'b0;
    m1_stb_i = 1'b1;
    #2;
    check("mid_cnt", 128'(dut.cnt_q), 128'(10));
    check("mid_own", 128'({biu_stb_o, owner_o}), 128'(3'b110));
    #1;
    HRESETn = 1'b0;
    #1;
    check("arst_out", 128'({biu_stb_o, owner_o}), 128'(3'b000));
    check("arst_cnt", 128'(dut.cnt_q), 128'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;
    m0_stb_i = 1'b1;
    m0_type_i = SINGLE;
    m1_type_i = SINGLE;
    @(negedge HCLK);
    #2;
    check("post_rst_grant", 128'({biu_stb_o, owner_o, m1_stb_ack_o}), 128'(4'b1010));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu_arb2.md
Name: biu_arb2

Overview:
- Two-requester arbiter for the BIU core-side bus. Shares one biu_ahb3lite instance between requester 0 (instruction fetch) and requester 1 (data access).
- Sits between the core memory stages and the AHB3-Lite bus interface.
- Forwards the granted requester's strobe/address/control/data to the BIU and routes acknowledge, error and read data back to it.
- Holds ownership until every beat of every accepted transfer has completed, so acknowledges always reach the requester that issued them.

Parameters:
- DATA_SIZE, 32, data width of all data ports.
- ADDR_SIZE, DATA_SIZE, address width of all address ports.
- MAX_PENDING, 32, maximum outstanding beats. Sets the pending-counter width as clog2(MAX_PENDING+1).

Ports:
- HRESETn  in  1  asynchronous active-low reset.
- HCLK  in  1  clock; all state updates on the rising edge.
- Requester ports, N = 0 and 1:
  - mN_stb_i  in  1  strobe.
  - mN_stb_ack_o  out  1  strobe accepted.
  - mN_d_ack_o  out  1  write data taken.
  - mN_adri_i  in  ADDR_SIZE  address.
  - mN_adro_o  out  ADDR_SIZE  address of the current data phase.
  - mN_size_i  in  biu_size_t  transfer size.
  - mN_type_i  in  biu_type_t  burst type.
  - mN_prot_i  in  biu_prot_t  protection.
  - mN_lock_i  in  1  hold ownership.
  - mN_we_i  in  1  write enable.
  - mN_d_i  in  DATA_SIZE  write data.
  - mN_q_o  out  DATA_SIZE  read data.
  - mN_ack_o  out  1  beat done.
  - mN_err_o  out  1  transfer error.
- BIU side:
  - biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_prot_o, biu_lock_o, biu_we_o, biu_d_o: out, widths as the requester inputs, to the BIU.
  - biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i: in, 1 bit each, from the BIU.
  - biu_adro_i: in, ADDR_SIZE, from the BIU.
  - biu_q_i: in, DATA_SIZE, from the BIU.
- Status:
  - owner_o  out  2  one-hot current owner; 00 when idle.

Behaviour:
- State machine: IDLE, OWN0, OWN1. Register last (last granted requester) and pending counter cnt.
- Reset values: state IDLE, cnt 0, last 1 (so requester 0 wins the first contention).
- Outputs in reset and in IDLE:
  - biu_stb_o=0, biu_lock_o=0, owner_o=00.
  - All mN_stb_ack_o, mN_d_ack_o, mN_ack_o, mN_err_o = 0.
  - biu_adri_o, biu_d_o and the other forwarded controls are don't-care but driven from requester 0.
- IDLE transitions:
  - Only m0_stb_i -> OWN0 next cycle.
  - Only m1_stb_i -> OWN1 next cycle.
  - Both -> the requester != last. last updates on entry.
  - Grant latency is 1 cycle from strobe to biu_stb_o.
- In OWNn:
  - All biu_*_o are driven combinationally from mN_*_i, including biu_stb_o = mN_stb_i.
  - biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i are routed to the owner only.
  - The non-owner's handshake outputs stay 0; its strobe waits, with no loss.
- mN_q_o = biu_q_i and mN_adro_o = biu_adro_i go to both requesters. Qualify them with ack.
- Beats per accepted strobe: SINGLE/INCR 1, WRAP4/INCR4 4, WRAP8/INCR8 8, WRAP16/INCR16 16.
- Pending counter update, each cycle:
  - cnt += beats on biu_stb_o & biu_stb_ack_i.
  - cnt -= 1 on biu_ack_i.
  - Both in the same cycle: apply both (net beats-1).
  - biu_err_i -> cnt := 0, overriding both. An add in the same cycle is ignored; biu_ahb3lite never acks a strobe in an error cycle.
- Admission limit: if cnt + beats(owner type) > MAX_PENDING, force biu_stb_o=0 until cnt drains.
- Release: from OWNn when cnt==0 (after update), mN_stb_i=0 and mN_lock_i=0.
  - If the other requester is strobing, go directly to OWNother; otherwise go to IDLE.
  - Pipelined same-owner strobes while cnt>0 are allowed and do not release.
- Lock: while the owner's lock_i=1, ownership is held even when cnt==0 and stb=0. biu_lock_o follows the owner's lock_i.
- Error: after an error, ownership releases per the normal rule. A strobe re-asserted by the owner is forwarded again.
- Async reset mid-burst: immediately IDLE, cnt 0, biu_stb_o 0. The BIU is reset by the same HRESETn.

Test Plan:
- m0 SINGLE read at addr 0x100, m1 idle:
  - biu_stb_o rises 1 cycle after m0_stb_i.
  - After biu_stb_ack_i, cnt=1.
  - biu_ack_i -> m0_ack_o=1 with q=biu_q_i; return to IDLE; m1 outputs stay 0.
- m0 and m1 strobe in the same cycle from reset:
  - OWN0 first; m0 INCR4 completes 4 acks (cnt 4->0).
  - Then direct OWN0->OWN1 with no idle cycle.
  - Next contention grants m0 (round-robin).
- m1 WRAP8 write with stb_ack and first ack in the same cycle as a second pipelined SINGLE:
  - cnt goes 0->8, then net +0, ...
  - Ownership held until cnt=0; exactly 9 m1_ack_o pulses.
- biu_err_i on beat 2 of an m0 INCR4 while m1 waiting:
  - m0_err_o=1 for 1 cycle, cnt=0.
  - m1 granted next cycle; m0 sees no further acks.
- m0_lock_i=1 with m0 stb low and cnt=0, m1 strobing for 5 cycles:
  - OWN0 held, m1_stb_ack_o=0.
  - Lock drops -> OWN1 next cycle.
- HRESETn low during an m1 INCR16 (cnt=10):
  - Asynchronously biu_stb_o=0, owner_o=00, cnt=0.
  - After release, m0 wins the first contention.
